// File: rtl/keypad_event_queue.sv
// -----------------------------------------------------------------------------
// keypad_event_queue
//
// Debounces the key-held flag and key code coming from the 4x4 keypad column
// scanner and turns every debounced press into exactly one event in a small
// FIFO. Holding a key never repeats the event. The FIFO is drained through a
// valid/ready handshake, and oIRQ is a level interrupt that mirrors oVALID.
//
// Parameters
//   DEBOUNCE_CYC  consecutive stable samples needed to accept a press/release (>=1)
//   DEPTH         FIFO entries (power of 2, >=2)
//
// Ports
//   iclk      in   clock, rising edge
//   inrest    in   synchronous active-low reset
//   iKEYIRQ   in   scanner key-held level (asynchronous to iclk)
//   iKEYNUM   in   scanner key code, 0x00-0x0F valid, 0xFF = none
//   iREADY    in   consumer takes the head entry when high together with oVALID
//   iOVF_CLR  in   clears the sticky overflow flag
//   oVALID    out  FIFO not empty
//   oDATA     out  head entry key code (holds last value when empty)
//   oCOUNT    out  number of stored entries
//   oHELD     out  debounced key-down state
//   oOVF      out  sticky: an event was dropped because the FIFO was full
//   oIRQ      out  level interrupt, equals oVALID
// -----------------------------------------------------------------------------
module keypad_event_queue #(
   parameter int DEBOUNCE_CYC = 1000,
   parameter int DEPTH        = 8
) (
   input  logic                       iclk,
   input  logic                       inrest,
   input  logic                       iKEYIRQ,
   input  logic [7:0]                 iKEYNUM,
   input  logic                       iREADY,
   input  logic                       iOVF_CLR,
   output logic                       oVALID,
   output logic [7:0]                 oDATA,
   output logic [$clog2(DEPTH+1)-1:0] oCOUNT,
   output logic                       oHELD,
   output logic                       oOVF,
   output logic                       oIRQ
);

   localparam int CNT_W       = $clog2(DEBOUNCE_CYC + 1);
   localparam int PTR_W       = $clog2(DEPTH);
   localparam int NUM_W       = $clog2(DEPTH + 1);
   localparam int SYNC_STAGES = 2;
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC);
   localparam logic [NUM_W-1:0] FULL_CNT = NUM_W'(DEPTH);
   localparam logic [7:0]       NO_KEY   = 8'hFF;

   // --------------------------------------------------------------------------
   // Two-flop synchronizer for the scanner outputs. Each stage keeps its own
   // flops; the last stage feeds the debouncer.
   // --------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : gSync
         logic       irqIn;
         logic [7:0] codeIn;
         logic       irqQ;
         logic [7:0] codeQ;

         if (gi == 0) begin : gFirst
            assign irqIn  = iKEYIRQ;
            assign codeIn = iKEYNUM;
         end else begin : gChain
            assign irqIn  = gSync[gi-1].irqQ;
            assign codeIn = gSync[gi-1].codeQ;
         end

         always_ff @(posedge iclk) begin
            if (!inrest) begin
               irqQ  <= 1'b0;
               codeQ <= NO_KEY;
            end else begin
               irqQ  <= irqIn;
               codeQ <= codeIn;
            end
         end
      end
   endgenerate

   logic       irq;
   logic [7:0] code;
   logic       validSample;

   assign irq         = gSync[SYNC_STAGES-1].irqQ;
   assign code        = gSync[SYNC_STAGES-1].codeQ;
   assign validSample = irq && (code != NO_KEY);

   // --------------------------------------------------------------------------
   // Debounce FSM
   // --------------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_WAIT = 2'd1,
      HELD       = 2'd2,
      REL_WAIT   = 2'd3
   } stateT;

   stateT            stateReg, stateNext;
   logic [CNT_W-1:0] cntReg, cntNext, cntInc;
   logic [7:0]       capReg, capNext;
   logic             push;
   logic [7:0]       pushData;

   assign cntInc = cntReg + CNT_W'(1);

   // A single-cycle debounce pushes straight from IDLE, before cap is loaded,
   // so the live code is used there.
   assign pushData = (stateReg == IDLE) ? code : capReg;

   always_ff @(posedge iclk) begin
      if (!inrest) begin
         stateReg <= IDLE;
         cntReg   <= '0;
         capReg   <= NO_KEY;
      end else begin
         stateReg <= stateNext;
         cntReg   <= cntNext;
         capReg   <= capNext;
      end
   end

   always_comb begin
      stateNext = stateReg;
      cntNext   = cntReg;
      capNext   = capReg;
      push      = 1'b0;
      case (stateReg)
         IDLE: begin
            if (validSample) begin
               capNext = code;
               if (DEBOUNCE_CYC == 1) begin
                  stateNext = HELD;
                  cntNext   = '0;
                  push      = 1'b1;
               end else begin
                  stateNext = PRESS_WAIT;
                  cntNext   = CNT_W'(1);
               end
            end
         end
         PRESS_WAIT: begin
            // Any glitch or code change restarts the press qualification.
            if (validSample && (code == capReg)) begin
               if (cntInc == DEB_LAST) begin
                  stateNext = HELD;
                  cntNext   = '0;
                  push      = 1'b1;
               end else begin
                  cntNext = cntInc;
               end
            end else begin
               stateNext = IDLE;
               cntNext   = '0;
            end
         end
         HELD: begin
            // Code changes while held are ignored; only the release matters.
            if (!irq) begin
               if (DEBOUNCE_CYC == 1) begin
                  stateNext = IDLE;
                  cntNext   = '0;
               end else begin
                  stateNext = REL_WAIT;
                  cntNext   = CNT_W'(1);
               end
            end
         end
         REL_WAIT: begin
            // A bounce during release returns to HELD without a new event.
            if (!irq) begin
               if (cntInc == DEB_LAST) begin
                  stateNext = IDLE;
                  cntNext   = '0;
               end else begin
                  cntNext = cntInc;
               end
            end else begin
               stateNext = HELD;
               cntNext   = '0;
            end
         end
         default: begin
            stateNext = IDLE;
            cntNext   = '0;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Event FIFO
   // --------------------------------------------------------------------------
   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wrPtrReg, rdPtrReg, rdPtrInc;
   logic [NUM_W-1:0] countReg;
   logic [7:0]       dataReg;
   logic             ovfReg;
   logic             pop, pushOk, pushDrop;

   assign pop      = (countReg != '0) && iREADY;
   assign pushOk   = push && ((countReg < FULL_CNT) || pop);
   assign pushDrop = push && !pushOk;
   assign rdPtrInc = rdPtrReg + PTR_W'(1);

   always_ff @(posedge iclk) begin
      if (pushOk) begin
         mem[wrPtrReg] <= pushData;
      end
   end

   always_ff @(posedge iclk) begin
      if (!inrest) begin
         wrPtrReg <= '0;
         rdPtrReg <= '0;
         countReg <= '0;
         dataReg  <= 8'h00;
         ovfReg   <= 1'b0;
      end else begin
         if (pushOk) begin
            wrPtrReg <= wrPtrReg + PTR_W'(1);
         end
         if (pop) begin
            rdPtrReg <= rdPtrInc;
         end

         case ({pushOk, pop})
            2'b10:   countReg <= countReg + NUM_W'(1);
            2'b01:   countReg <= countReg - NUM_W'(1);
            default: countReg <= countReg;
         endcase

         // Head register: after a pop the next stored entry moves up; when
         // the FIFO is (or becomes) empty, the incoming entry bypasses the
         // array. Reaching the second branch with pop set means count was 1.
         if (pop && (countReg > NUM_W'(1))) begin
            dataReg <= mem[rdPtrInc];
         end else if (pushOk && ((countReg == '0) || pop)) begin
            dataReg <= pushData;
         end

         if (pushDrop) begin
            ovfReg <= 1'b1;
         end else if (iOVF_CLR) begin
            ovfReg <= 1'b0;
         end
      end
   end

   assign oVALID = (countReg != '0);
   assign oIRQ   = (countReg != '0);
   assign oCOUNT = countReg;
   assign oDATA  = dataReg;
   assign oOVF   = ovfReg;
   assign oHELD  = (stateReg == HELD) || (stateReg == REL_WAIT);

endmodule

// File: tb/tb_keypad_event_queue.sv
// -----------------------------------------------------------------------------
// tb_keypad_event_queue
//
// Directed bench for keypad_event_queue with DEBOUNCE_CYC=4 and DEPTH=4.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_keypad_event_queue;

   logic       iclk;
   logic       inrest;
   logic       iKEYIRQ;
   logic [7:0] iKEYNUM;
   logic       iREADY;
   logic       iOVF_CLR;
   logic       oVALID;
   logic [7:0] oDATA;
   logic [2:0] oCOUNT;
   logic       oHELD;
   logic       oOVF;
   logic       oIRQ;

   int checks = 0;
   int errors = 0;

   keypad_event_queue #(
      .DEBOUNCE_CYC (4),
      .DEPTH        (4)
   ) dut (
      .iclk     (iclk),
      .inrest   (inrest),
      .iKEYIRQ  (iKEYIRQ),
      .iKEYNUM  (iKEYNUM),
      .iREADY   (iREADY),
      .iOVF_CLR (iOVF_CLR),
      .oVALID   (oVALID),
      .oDATA    (oDATA),
      .oCOUNT   (oCOUNT),
      .oHELD    (oHELD),
      .oOVF     (oOVF),
      .oIRQ     (oIRQ)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge iclk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic keyDown(input logic [7:0] k, input int n);
      iKEYIRQ = 1'b1;
      iKEYNUM = k;
      tick(n);
   endtask

   task automatic keyUp(input int n);
      iKEYIRQ = 1'b0;
      iKEYNUM = 8'hFF;
      tick(n);
   endtask

   task automatic popOne(input string tag, input logic [7:0] exp);
      chk({tag, "_valid"}, oVALID, 1'b1);
      chk({tag, "_data"}, oDATA, exp);
      $display("pop %s data=%02h count=%0d", tag, oDATA, oCOUNT);
      iREADY = 1'b1;
      tick(1);
      iREADY = 1'b0;
   endtask

   initial begin
      inrest   = 1'b0;
      iKEYIRQ  = 1'b0;
      iKEYNUM  = 8'hFF;
      iREADY   = 1'b0;
      iOVF_CLR = 1'b0;
      tick(3);

      // Reset state
      chk("rst_valid", oVALID, 1'b0);
      chk("rst_irq",   oIRQ,   1'b0);
      chk("rst_held",  oHELD,  1'b0);
      chk("rst_ovf",   oOVF,   1'b0);
      chk("rst_data",  oDATA,  8'h00);
      chk("rst_count", oCOUNT, 3'd0);
      inrest = 1'b1;
      tick(2);

      // Clean press: push lands on edge 5 counted from the first valid edge 0
      keyDown(8'h05, 5);
      chk("press_early_valid", oVALID, 1'b0);
      tick(1);
      chk("press_valid", oVALID, 1'b1);
      chk("press_irq",   oIRQ,   1'b1);
      chk("press_data",  oDATA,  8'h05);
      chk("press_count", oCOUNT, 3'd1);
      chk("press_held",  oHELD,  1'b1);
      $display("press 05 queued count=%0d", oCOUNT);
      tick(14);
      chk("press_hold_count", oCOUNT, 3'd1);
      iREADY = 1'b1;
      tick(1);
      iREADY = 1'b0;
      chk("pop_count",  oCOUNT, 3'd0);
      chk("pop_irq",    oIRQ,   1'b0);
      chk("pop_data_hold", oDATA, 8'h05);
      // Release: oHELD falls after the sixth edge
      keyUp(5);
      chk("rel_early_held", oHELD, 1'b1);
      tick(1);
      chk("rel_held", oHELD, 1'b0);
      tick(4);

      // Bounce: never 4 consecutive stable samples
      keyDown(8'h07, 3);
      keyUp(1);
      keyDown(8'h07, 3);
      keyUp(1);
      tick(6);
      chk("bounce_count", oCOUNT, 3'd0);
      chk("bounce_held",  oHELD,  1'b0);
      $display("bounce 07 count=%0d", oCOUNT);

      // Hold and repress
      keyDown(8'h02, 100);
      chk("hold_count", oCOUNT, 3'd1);
      chk("hold_held",  oHELD,  1'b1);
      keyUp(3);
      keyDown(8'h02, 20);
      chk("repress_count", oCOUNT, 3'd1);
      keyUp(8);
      chk("repress_rel_held", oHELD, 1'b0);
      keyDown(8'h0A, 10);
      chk("second_count", oCOUNT, 3'd2);
      keyUp(8);
      popOne("hold_pop0", 8'h02);
      popOne("hold_pop1", 8'h0A);
      chk("hold_drained", oCOUNT, 3'd0);

      // Overflow: five presses into a four-entry FIFO
      keyDown(8'h01, 8); keyUp(8);
      keyDown(8'h02, 8); keyUp(8);
      keyDown(8'h03, 8); keyUp(8);
      keyDown(8'h04, 8); keyUp(8);
      chk("full_count", oCOUNT, 3'd4);
      chk("full_ovf",   oOVF,   1'b0);
      keyDown(8'h06, 8); keyUp(8);
      chk("ovf_count", oCOUNT, 3'd4);
      chk("ovf_flag",  oOVF,   1'b1);
      popOne("ovf_pop0", 8'h01);
      popOne("ovf_pop1", 8'h02);
      popOne("ovf_pop2", 8'h03);
      popOne("ovf_pop3", 8'h04);
      chk("ovf_drained", oCOUNT, 3'd0);
      chk("ovf_sticky",  oOVF,   1'b1);
      iOVF_CLR = 1'b1;
      tick(1);
      iOVF_CLR = 1'b0;
      chk("ovf_clr", oOVF, 1'b0);

      // Full FIFO with a push and pop on the same edge
      keyDown(8'h01, 8); keyUp(8);
      keyDown(8'h02, 8); keyUp(8);
      keyDown(8'h03, 8); keyUp(8);
      keyDown(8'h04, 8); keyUp(8);
      chk("sim_full_count", oCOUNT, 3'd4);
      keyDown(8'h09, 5);
      iREADY = 1'b1;
      tick(1);
      iREADY = 1'b0;
      chk("sim_count", oCOUNT, 3'd4);
      chk("sim_ovf",   oOVF,   1'b0);
      chk("sim_held",  oHELD,  1'b1);
      keyUp(8);
      popOne("sim_pop0", 8'h02);
      popOne("sim_pop1", 8'h03);
      popOne("sim_pop2", 8'h04);
      popOne("sim_pop3", 8'h09);
      chk("sim_drained", oCOUNT, 3'd0);

      // Reset in PRESS_WAIT with two entries queued and the key held
      keyDown(8'h03, 8); keyUp(8);
      keyDown(8'h05, 8); keyUp(8);
      chk("pre_rst_count", oCOUNT, 3'd2);
      keyDown(8'h0C, 3);
      inrest = 1'b0;
      tick(1);
      inrest = 1'b1;
      chk("mid_rst_count", oCOUNT, 3'd0);
      chk("mid_rst_valid", oVALID, 1'b0);
      chk("mid_rst_irq",   oIRQ,   1'b0);
      chk("mid_rst_held",  oHELD,  1'b0);
      chk("mid_rst_ovf",   oOVF,   1'b0);
      chk("mid_rst_data",  oDATA,  8'h00);
      tick(5);
      chk("post_rst_early_count", oCOUNT, 3'd0);
      tick(1);
      chk("post_rst_count", oCOUNT, 3'd1);
      chk("post_rst_data",  oDATA,  8'h0C);
      $display("press 0C after reset count=%0d", oCOUNT);
      tick(20);
      chk("post_rst_hold_count", oCOUNT, 3'd1);
      keyUp(8);
      popOne("post_rst_pop", 8'h0C);
      chk("final_count", oCOUNT, 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_event_queue.md
# keypad_event_queue

Debounces the keypad scanner's key-held flag and key code and turns each debounced key press into one event in a small FIFO. Software or a downstream FSM drains it through a valid/ready handshake. Sits directly downstream of the 4x4 keypad column scanner; its interrupt output feeds the AXI interrupt/register wrapper of the reaction-speed tester. One event is generated per physical press; holding a key never repeats it.

## Interface
- DEBOUNCE_CYC, 1000, consecutive stable cycles required to accept a press or a release; must be ≥1.
- DEPTH, 8, FIFO entries; power of 2, ≥2.
- iclk  in  1  clock, rising edge only.
- inrest  in  1  reset, synchronous, active-low.
- iKEYIRQ  in  1  scanner key-held level; 1 = some row is low.
- iKEYNUM  in  8  scanner key code, 0x00–0x0F valid; 0xFF = none.
- iREADY  in  1  consumer accepts the head entry when high with oVALID.
- iOVF_CLR  in  1  clears oOVF; level, sampled each cycle.
- oVALID  out  1  FIFO non-empty.
- oDATA  out  8  head entry key code; holds its last value when the FIFO is empty.
- oCOUNT  out  $clog2(DEPTH+1)  entries stored.
- oHELD  out  1  debounced key-down state.
- oOVF  out  1  sticky: an event was dropped because the FIFO was full.
- oIRQ  out  1  level, equals oVALID.

## Operation
- **Input synchronizer:** iKEYIRQ and iKEYNUM each pass through 2 flops (s1, s2). Reset value is 0 for iKEYIRQ and 0xFF for iKEYNUM. All logic below uses the s2 values: irq, code.
- **Valid sample:** irq=1 and code≠0xFF.
- **Debounce FSM:** states IDLE, PRESS_WAIT, HELD, REL_WAIT. Counter width is $clog2(DEBOUNCE_CYC+1). A captured-code register is cap.
  - IDLE: on a valid sample, go to PRESS_WAIT, set cap=code and cnt=1. If DEBOUNCE_CYC=1, go directly to HELD and push.
  - PRESS_WAIT:
    - Valid sample with code==cap: cnt+1. When cnt+1==DEBOUNCE_CYC, go to HELD and push cap.
    - Any other sample: go to IDLE, cnt=0.
  - HELD: irq=0 goes to REL_WAIT with cnt=1. A code change while held is ignored.
  - REL_WAIT:
    - irq=0: cnt+1. When cnt+1==DEBOUNCE_CYC, go to IDLE.
    - irq=1: go back to HELD, cnt=0, no new event.
  - If DEBOUNCE_CYC=1, HELD goes directly to IDLE on irq=0.
- **oHELD** = state is HELD or REL_WAIT.
- **FIFO:**
  - Circular buffer with read and write pointers of width $clog2(DEPTH); pointers wrap modulo DEPTH.
  - pop = oVALID & iREADY.
  - push_ok = push & (oCOUNT<DEPTH | pop).
  - When full, a simultaneous push and pop both succeed and oCOUNT stays at DEPTH.
  - A push rejected while full sets oOVF; the entry is discarded.
  - oCOUNT updates as +1, −1, or 0 for push-only, pop-only, or both/neither.
- **oOVF:** set by a rejected push, cleared by iOVF_CLR. If both occur in the same cycle, set wins.
- **Reset (inrest=0 at an edge):**
  - FSM goes to IDLE; cnt=0; cap=0xFF; pointers=0.
  - oCOUNT=0, oVALID=0, oIRQ=0, oHELD=0, oOVF=0, oDATA=0x00.
  - Synchronizer flops take their reset values.
  - Reset mid-press drops the pending press. A key still held after reset is debounced anew and yields one event.

## Timing
- **Press latency:** irq and code are first valid before edge 0 and remain stable. The push occurs at edge DEBOUNCE_CYC+1 (2 synchronizer edges plus DEBOUNCE_CYC samples). oVALID, oIRQ, oHELD and oDATA are valid after that edge.
- **Release:** oHELD falls DEBOUNCE_CYC+2 edges after irq first goes low.
- **Pop:** the handshake completes at the edge where oVALID&iREADY=1. oDATA shows the next entry, and oCOUNT decrements, after that edge. Back-to-back pops every cycle are supported.
- oDATA is registered or read from the array with no combinational path from iREADY. oVALID and oIRQ are derived from registered oCOUNT only.

## Test plan
All scenarios use DEBOUNCE_CYC=4, DEPTH=4.
- **Clean press:** iKEYNUM=0x05, iKEYIRQ=1 for 20 cycles, iREADY=0 → oVALID and oIRQ rise after edge 5; oDATA=0x05; oCOUNT=1; oHELD=1. Then pulse iREADY for 1 cycle → oCOUNT=0, oIRQ=0.
- **Bounce:** irq high 3 cycles, low 1, high 3, low 1 with code 0x07 → no push; oCOUNT stays 0.
- **Hold and repress:**
  - 0x02 held 100 cycles → exactly 1 event.
  - Release 3 cycles, then re-press 0x02 → still 1 event.
  - Release ≥6 cycles, then press 0x0A → 2 events, in order 0x02, 0x0A.
- **Overflow:** 5 distinct presses (0x01,0x02,0x03,0x04,0x06) with iREADY=0 → oCOUNT=4, oOVF=1, drained order 0x01–0x04. Assert iOVF_CLR → oOVF=0.
- **Full with simultaneous push/pop:** FIFO full (0x01–0x04), iREADY=1 held on the push edge of 0x09 → oCOUNT stays 4, oOVF=0, drained order 0x02,0x03,0x04,0x09.
- **Reset mid-operation:** assert inrest=0 for 1 cycle while in PRESS_WAIT with 2 entries queued, key still held → all outputs at reset values. Exactly one event for the held key appears 6 edges after reset release.
